// File: rtl/seg7_pkg.sv
// +--------------------------------------------------------------------------+
// | seg7_pkg: pattern and code constants shared by the 7-segment encoder and  |
// | the scan reader. Revision: 1.0                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package seg7_pkg;

  typedef logic [3:0] seg7_code_t;

  // Active-high patterns, bit7 = dp, bits6..0 = g..a
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h67;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_DOT   = 8'h80;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam seg7_code_t CODE_DASH    = 4'hA;
  localparam seg7_code_t CODE_DOT     = 4'hB;
  localparam seg7_code_t CODE_INVALID = 4'hE;
  localparam seg7_code_t CODE_BLANK   = 4'hF;

endpackage

`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
// +--------------------------------------------------------------------------+
// | seg7_pattern_decode: active-low segment pattern to 4-bit code + error.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [7:0] pattern_n_i,
  output logic [3:0] code_o,
  output logic       err_o
);

  logic [7:0] pattern;

  always_comb begin
    pattern = ~pattern_n_i;
    code_o  = CODE_INVALID;
    err_o   = 1'b0;
    case (pattern)
      SEG_0:     code_o = 4'h0;
      SEG_1:     code_o = 4'h1;
      SEG_2:     code_o = 4'h2;
      SEG_3:     code_o = 4'h3;
      SEG_4:     code_o = 4'h4;
      SEG_5:     code_o = 4'h5;
      SEG_6:     code_o = 4'h6;
      SEG_7:     code_o = 4'h7;
      SEG_8:     code_o = 4'h8;
      SEG_9:     code_o = 4'h9;
      SEG_DASH:  code_o = CODE_DASH;
      SEG_DOT:   code_o = CODE_DOT;
      SEG_BLANK: code_o = CODE_BLANK;
      default: begin
        code_o = CODE_INVALID;
        err_o  = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_reader.sv
// +--------------------------------------------------------------------------+
// | seg7_scan_reader: snoops a multiplexed active-low 7-segment bus and       |
// | recovers the stable code of each digit. Revision: 1.0                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digit_code,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    scan_err
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 1);

  logic [7:0]              seg_q, seg_prev_q;
  logic [NUM_DIGITS-1:0]   an_q, an_prev_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] code_q, code_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    scan_err_q, scan_err_d;

  logic [NUM_DIGITS-1:0]   act;
  logic                    one_hot;
  logic                    multi;
  logic                    same;
  logic                    capture;
  logic [IDX_W-1:0]        idx;
  seg7_code_t              dec_code;
  logic                    dec_err;

  seg7_pattern_decode u_decode (
    .pattern_n_i (seg_q),
    .code_o      (dec_code),
    .err_o       (dec_err)
  );

  always_comb begin
    act     = ~an_q;
    multi   = (act & (act - 1'b1)) != '0;
    one_hot = (act != '0) && !multi;
    same    = (seg_q == seg_prev_q) && (an_q == an_prev_q);
    idx     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (act[i]) idx = IDX_W'(i);
    end

    // A saturated counter never re-enters CNT_CAP, so each dwell captures once
    capture = one_hot && same && (cnt_q == CNT_CAP);
    if (!one_hot)        cnt_d = '0;
    else if (!same)      cnt_d = CNT_W'(1);
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                 cnt_d = cnt_q + 1'b1;

    code_d = code_q;
    err_d  = err_q;
    if (capture) begin
      code_d[4*idx +: 4] = dec_code;
      err_d[idx]         = dec_err;
    end

    // Completion is flagged one edge after the mask fills; a capture on that
    // same edge lands in the freshly cleared mask.
    frame_valid_d = &seen_q;
    seen_d        = frame_valid_d ? '0 : seen_q;
    if (capture) seen_d[idx] = 1'b1;

    scan_err_d = multi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q         <= 8'hFF;
      an_q          <= '1;
      seg_prev_q    <= 8'hFF;
      an_prev_q     <= '1;
      cnt_q         <= '0;
      seen_q        <= '0;
      code_q        <= '1;
      err_q         <= '0;
      frame_valid_q <= 1'b0;
      scan_err_q    <= 1'b0;
    end else begin
      seg_q         <= seg_n;
      an_q          <= an_n;
      seg_prev_q    <= seg_q;
      an_prev_q     <= an_q;
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      code_q        <= code_d;
      err_q         <= err_d;
      frame_valid_q <= frame_valid_d;
      scan_err_q    <= scan_err_d;
    end
  end

  assign digit_code  = code_q;
  assign digit_err   = err_q;
  assign frame_valid = frame_valid_q;
  assign scan_err    = scan_err_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_reader.sv
// +--------------------------------------------------------------------------+
// | tb_seg7_scan_reader: directed and random scan sequences checked against   |
// | a run-length reference model. Revision: 1.0                               |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_seg7_scan_reader;

  localparam int N = 4;
  localparam int S = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     seg_n;
  logic [N-1:0]   an_n;
  logic [4*N-1:0] digit_code;
  logic [N-1:0]   digit_err;
  logic           frame_valid;
  logic           scan_err;

  always #5 clk = ~clk;

  seg7_scan_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .digit_code  (digit_code),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .scan_err    (scan_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int fv_seen  = 0;
  int se_seen  = 0;

  logic [7:0] digit_pat [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h67};
  logic [7:0] any_pat [13] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D,
                               8'h07, 8'h7F, 8'h67, 8'h40, 8'h80, 8'h00};

  // Model: stored codes, seen mask, pending sample and its run length
  logic [3:0]   m_code [N];
  logic [N-1:0] m_err, m_seen;
  logic         m_fv, m_se;
  logic [N-1:0] p_an;
  logic [7:0]   p_seg;
  int           run;

  function automatic int ones(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic ref_decode(input logic [7:0] sn, output logic [3:0] code, output logic err);
    logic [7:0] p;
    p    = ~sn;
    code = 4'hE;
    err  = 1'b1;
    for (int i = 0; i < 10; i++)
      if (p == digit_pat[i]) begin code = 4'(i); err = 1'b0; end
    if (p == 8'h40) begin code = 4'hA; err = 1'b0; end
    if (p == 8'h80) begin code = 4'hB; err = 1'b0; end
    if (p == 8'h00) begin code = 4'hF; err = 1'b0; end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_code[i] = 4'hF;
    m_err  = '0;
    m_seen = '0;
    m_fv   = 1'b0;
    m_se   = 1'b0;
    p_an   = '1;
    p_seg  = 8'hFF;
    run    = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] an, input logic [7:0] sg);
    logic [3:0] c;
    logic       e;
    int         idx;
    m_fv = (m_seen == '1);
    if (m_fv) m_seen = '0;
    m_se = ones(~p_an) > 1;
    if (run == S) begin
      idx = 0;
      for (int i = 0; i < N; i++) if (!p_an[i]) idx = i;
      ref_decode(p_seg, c, e);
      m_code[idx] = c;
      m_err[idx]  = e;
      m_seen[idx] = 1'b1;
    end
    if (ones(~an) == 1) run = (an == p_an && sg == p_seg) ? run + 1 : 1;
    else                run = 0;
    p_an  = an;
    p_seg = sg;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [4*N-1:0] ec;
    for (int i = 0; i < N; i++) ec[4*i +: 4] = m_code[i];
    chk("digit_code", 32'(digit_code), 32'(ec));
    chk("digit_err", 32'(digit_err), 32'(m_err));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("scan_err", 32'(scan_err), 32'(m_se));
    if (frame_valid === 1'b1) fv_seen++;
    if (scan_err === 1'b1) se_seen++;
  endtask

  task automatic cyc(input logic [N-1:0] an, input logic [7:0] sg);
    an_n  = an;
    seg_n = sg;
    @(posedge clk);
    model_edge(an, sg);
    #1;
    check_all();
  endtask

  task automatic dwell(input logic [N-1:0] an, input logic [7:0] sg, input int len, input int gap);
    repeat (len) cyc(an, sg);
    repeat (gap) cyc('1, 8'hFF);
  endtask

  initial begin
    logic [N-1:0] an_r, tmp;
    logic [7:0]   sg_r;
    int           a, b, k;

    rst   = 1'b1;
    an_n  = '1;
    seg_n = 8'hFF;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    dwell('1, 8'hFF, 50, 0);
    chk("idle_code", 32'(digit_code), 32'h0000_FFFF);

    fv_seen = 0;
    dwell(4'b1110, 8'hC0, 10, 2);
    dwell(4'b1101, 8'hF9, 10, 2);
    dwell(4'b1011, 8'hA4, 10, 2);
    dwell(4'b0111, 8'hB0, 10, 2);
    chk("frame_code", 32'(digit_code), 32'h0000_3210);
    chk("frame_err", 32'(digit_err), 32'h0);
    chk("frame_pulses", 32'(fv_seen), 32'd1);

    dwell(4'b1110, 8'hBF, 9, 2);
    dwell(4'b1101, 8'h7F, 9, 2);
    dwell(4'b1011, 8'h00, 9, 2);
    chk("dash_code", 32'(digit_code[3:0]), 32'hA);
    chk("dot_code", 32'(digit_code[7:4]), 32'hB);
    chk("invalid_code", 32'(digit_code[11:8]), 32'hE);
    chk("invalid_err", 32'(digit_err[2]), 32'h1);

    dwell(4'b1110, 8'hF9, 7, 2);
    chk("ghost_7", 32'(digit_code[3:0]), 32'hA);
    dwell(4'b1110, 8'hF9, 8, 0);
    chk("dwell8_edge8", 32'(digit_code[3:0]), 32'hA);
    cyc('1, 8'hFF);
    chk("dwell8_edge9", 32'(digit_code[3:0]), 32'h1);

    se_seen = 0;
    dwell(4'b1100, 8'hC0, 3, 1);
    chk("multi_pulses", 32'(se_seen), 32'd3);
    chk("multi_nocap", 32'(digit_code[3:0]), 32'h1);
    dwell(4'b1110, 8'h99, 8, 1);
    chk("after_multi", 32'(digit_code[3:0]), 32'h4);

    dwell(4'b1101, 8'hA4, 4, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_code", 32'(digit_code), 32'h0000_FFFF);
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    dwell(4'b1101, 8'hA4, 8, 0);
    chk("post_rst_8", 32'(digit_code[7:4]), 32'hF);
    cyc(4'b1101, 8'hA4);
    chk("post_rst_9", 32'(digit_code[7:4]), 32'h2);

    for (int d = 0; d < 300; d++) begin
      k = $urandom_range(0, 9);
      if (k < 7) begin
        tmp = '0;
        tmp[$urandom_range(0, N-1)] = 1'b1;
        an_r = ~tmp;
      end else if (k == 7) begin
        an_r = '1;
      end else if (k == 8) begin
        a = $urandom_range(0, N-1);
        b = (a + $urandom_range(1, N-1)) % N;
        tmp = '0;
        tmp[a] = 1'b1;
        tmp[b] = 1'b1;
        an_r = ~tmp;
      end else begin
        an_r = N'($urandom);
      end
      if ($urandom_range(0, 1) == 0) sg_r = ~any_pat[$urandom_range(0, 12)];
      else                           sg_r = 8'($urandom);
      dwell(an_r, sg_r, $urandom_range(1, 12), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Receiving end of the team's active-low 7-segment display interface: monitors a time-multiplexed display bus (active-low segments plus active-low digit anodes) and recovers the 4-bit code shown on each digit.
- Used as an on-board loopback checker and display snooper behind the ALU output path.
- Applies a per-digit stability filter, classifies each pattern, stores the result per digit and pulses once per complete scan frame.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; an_n width.
- STABLE_CYCLES, 8, consecutive identical samples required before capture; minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg_n  in  8  active-low segments: bit7 = dp, bits6..0 = g..a.
- an_n  in  NUM_DIGITS  active-low digit enables; bit i selects digit i.
- digit_code  out  4*NUM_DIGITS  recovered codes; digit i occupies bits [4i+3:4i].
- digit_err  out  NUM_DIGITS  1 = last capture of digit i was an unrecognised pattern.
- frame_valid  out  1  one-cycle pulse when every digit has been captured since the last pulse.
- scan_err  out  1  one-cycle pulse for each sampled cycle with more than one anode active.

Behaviour:
- Reset, asynchronous on rst high:
  - digit_code = all 4'hF; digit_err = 0; frame_valid = 0; scan_err = 0.
  - Stability counter = 0; seen mask = 0.
  - Sample registers: seg_n = 8'hFF, an_n = all ones.
- Input stage: seg_n and an_n are registered once on every edge. All logic below works on these samples.
- Decode of the sampled pattern, after inversion to active-high:
  - 0x3F,06,5B,4F,66,6D,7D,07,7F,67 -> 0..9.
  - 0x40 ('-') -> 4'hA; 0x80 ('.') -> 4'hB; 0x00 (blank) -> 4'hF.
  - Every other pattern -> code 4'hE with err = 1. For all listed patterns err = 0.
- Stability counter, saturating at STABLE_CYCLES:
  - Sample has exactly one anode active and (an, seg) equals the previous sample: increment.
  - Exactly one anode active but the sample differs from the previous one: load 1.
  - Zero or multiple anodes active: load 0.
- Capture:
  - Occurs on the edge where the counter transitions from STABLE_CYCLES-1 to STABLE_CYCLES.
  - Writes digit_code[idx] and digit_err[idx], and sets seen[idx]. idx is the index of the active anode.
  - Only one capture per dwell; a saturated counter does not re-capture.
  - Latency: inputs held across edges 1..STABLE_CYCLES+1 produce updated outputs after edge STABLE_CYCLES+1.
  - A dwell shorter than STABLE_CYCLES samples (ghosting or glitches) never captures.
- Re-capture of a digit before the frame completes overwrites its code and err bit silently. seen stays set.
- Frame completion:
  - On the edge after a capture that makes seen all ones, frame_valid = 1 for exactly one cycle and seen clears.
  - A capture in that same cycle sets its seen bit in the new, cleared mask.
- scan_err: registered; high for the cycle following each multi-anode sample. It does not alter stored digits.
- Reset mid-dwell clears the counter. After release, a full STABLE_CYCLES dwell is needed again.

Decomposition:
- Shared package seg7_pkg holds:
  - Active-high pattern constants SEG_0..SEG_9, SEG_DASH, SEG_DOT, SEG_BLANK.
  - Code constants CODE_DASH = 4'hA, CODE_DOT = 4'hB, CODE_INVALID = 4'hE, CODE_BLANK = 4'hF.
  - Shared with the display encoder.
- Sub-module seg7_pattern_decode: combinational, 8-bit active-low pattern in; 4-bit code plus err out.
- The top level holds the sample registers, one-hot check and index encode, counter, digit storage and frame logic.

Test Plan:
- Reset, then idle inputs (an_n = 4'hF) for 50 cycles -> digit_code = 16'hFFFF; digit_err, frame_valid and scan_err stay 0.
- Defaults; dwell 10 cycles each, 2 blank cycles between dwells:
  - Apply an_n = 1110/1101/1011/0111 with seg_n = C0/F9/A4/B0.
  - Required: digit_code = 16'h3210 and digit_err = 0.
  - frame_valid pulses exactly once, one edge after the digit 3 capture.
- Digit 0 with seg_n = BF for 9 cycles and digit 1 with seg_n = 7F for 9 cycles -> codes 4'hA and 4'hB.
  - Then digit 2 with seg_n = 00 for 9 cycles -> code 4'hE and digit_err[2] = 1.
- Ghost dwell: an_n = 1110, seg_n = F9 for only 7 cycles -> digit 0 unchanged, no capture.
  - The same dwell for 8 cycles -> captured exactly STABLE_CYCLES+1 edges after first application.
- an_n = 1100 for 3 cycles -> three scan_err pulses, counter 0, no capture.
  - Following a valid 8-cycle dwell on digit 0, the digit captures normally.
- Assert rst at the 5th cycle of a dwell on digit 1 (seg_n = A4) -> all outputs return to reset values.
  - Keep the same inputs after release -> capture occurs only after 8 further samples.
